// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg
// Shared types and reference model for the OR-gate sweep sequencer.
//   state_t          : sequencer FSM states (IDLE / DRIVE / DONE)
//   VEC_FIRST/LAST   : first and last vector of a sweep; vectors step 00->01->10->11
//   expected_or(vec) : golden OR result for a vector, where a=vec[0], b=vec[1]
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] VEC_FIRST = 2'b00;
  localparam logic [1:0] VEC_LAST  = 2'b11;

  function automatic logic expected_or(input logic [1:0] vec);
    return vec[0] | vec[1];
  endfunction

endpackage

// File: rtl/gate_sweep_timer.sv
// gate_sweep_timer
// Hold timer that counts 0..HOLD_CYCLES-1 and wraps.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (count -> 0)
//   clr  : synchronous clear to 0 (has priority over en)
//   en   : advance the count
//   last : high while the count equals HOLD_CYCLES-1
module gate_sweep_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [TW-1:0] cnt;

  assign last = (cnt == TW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/gate_sweep_seq.sv
// gate_sweep_seq
// Self-checking stimulus sequencer for a two-input OR gate. On an accepted
// start it walks a/b through 00,01,10,11 for PASSES sweeps, holding each vector
// HOLD_CYCLES cycles and comparing or_o against the expected OR on the last
// hold cycle. Mismatches are counted in a saturating counter.
// Parameters: HOLD_CYCLES (>=2), PASSES (>=1), CNT_W (error counter width).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : level-sampled run request (only honoured in IDLE)
//   a, b       : gate inputs, registered
//   or_o       : gate output under check
//   busy       : sweep in progress
//   done       : one-cycle end-of-run pulse
//   pass       : last completed run had zero mismatches
//   err_cnt    : mismatch count of current/last run, saturating
//   vec_idx    : current vector, a=vec_idx[0], b=vec_idx[1]
// Optional feature macro GATE_SWEEP_ERRLOG_EN adds first_err_vld/first_err_vec,
// which capture the vector of the first mismatch in a run.
module gate_sweep_seq
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int PASSES      = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             or_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       vec_idx
`ifdef GATE_SWEEP_ERRLOG_EN
  ,
  output logic             first_err_vld,
  output logic [1:0]       first_err_vec
`endif
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  // Saturating increment of the error counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  state_t           state, state_nxt;
  logic [PW-1:0]    pass_cnt;
  logic             timer_last;
  logic             start_acc;
  logic             sample;
  logic             mismatch;
  logic             run_end;
  logic [1:0]       vec_nxt;
  logic [CNT_W-1:0] err_nxt;

  assign start_acc = (state == IDLE) && start;
  assign sample    = (state == DRIVE) && timer_last;
  assign mismatch  = sample && (or_o != expected_or(vec_idx));
  assign run_end   = sample && (vec_idx == VEC_LAST) && (pass_cnt == PW'(PASSES - 1));

  gate_sweep_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .en   (state == DRIVE),
    .last (timer_last)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = DRIVE;
      DRIVE:   if (run_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next vector and next error count; outputs are registered from these so
  // a/b change on the same edge as vec_idx.
  always_comb begin
    vec_nxt = vec_idx;
    err_nxt = err_cnt;
    if (start_acc) begin
      vec_nxt = VEC_FIRST;
      err_nxt = '0;
    end else begin
      if (sample)   vec_nxt = vec_idx + 2'd1;
      if (mismatch) err_nxt = sat_inc(err_cnt);
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx  <= VEC_FIRST;
      pass_cnt <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
    end else begin
      vec_idx <= vec_nxt;
      err_cnt <= err_nxt;
      busy    <= (state_nxt == DRIVE);
      done    <= (state_nxt == DONE);
      // Gate inputs idle at 00 outside DRIVE.
      a       <= (state_nxt == DRIVE) ? vec_nxt[0] : 1'b0;
      b       <= (state_nxt == DRIVE) ? vec_nxt[1] : 1'b0;
      if (start_acc) begin
        pass_cnt <= '0;
        pass     <= 1'b0;
      end else begin
        if (sample && (vec_idx == VEC_LAST)) pass_cnt <= pass_cnt + PW'(1);
        // Final count includes the last sample's compare.
        if (run_end) pass <= (err_nxt == '0);
      end
    end
  end

`ifdef GATE_SWEEP_ERRLOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_vld <= 1'b0;
      first_err_vec <= 2'b00;
    end else if (start_acc) begin
      first_err_vld <= 1'b0;
      first_err_vec <= 2'b00;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_vec <= vec_idx;
    end
  end
`endif

endmodule

// File: tb/tb_gate_sweep_seq.sv
// tb_gate_sweep_seq
// Directed bench for gate_sweep_seq. dut drives a modelled OR gate whose
// behaviour is selectable (good / stuck-at-0 / inverted); dut2 (CNT_W=2)
// always sees an inverted gate to exercise counter saturation.
module tb_gate_sweep_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a, b, or_o;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] vec_idx;
  logic       a2, b2, or_o2;
  logic       busy2, done2, pass2;
  logic [1:0] err_cnt2;
  logic [1:0] vec_idx2;
`ifdef GATE_SWEEP_ERRLOG_EN
  logic       first_err_vld, first_err_vld2;
  logic [1:0] first_err_vec, first_err_vec2;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 good OR, 1 stuck at 0, 2 inverted

  always_comb begin
    case (mode)
      0:       or_o = a | b;
      1:       or_o = 1'b0;
      default: or_o = ~(a | b);
    endcase
  end
  assign or_o2 = ~(a2 | b2);

  gate_sweep_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .or_o(or_o),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_idx(vec_idx)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .first_err_vld(first_err_vld), .first_err_vec(first_err_vec)
`endif
  );

  gate_sweep_seq #(.HOLD_CYCLES(10), .PASSES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a(a2), .b(b2), .or_o(or_o2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .vec_idx(vec_idx2)
`ifdef GATE_SWEEP_ERRLOG_EN
    , .first_err_vld(first_err_vld2), .first_err_vec(first_err_vec2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done. n is the number
  // of edges from the start edge (inclusive) to the edge that raised done.
  task automatic run_pulse(output int n);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
  endtask

  int n;
  int done_seen;
  int ok;
  logic [1:0] exp_vec;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err",  err_cnt, 0);
    check("rst_ab",   {b, a}, 0);
    check("rst_vec",  vec_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    // Good gate: check vector sequence cycle by cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy_first", busy, 1);
    ok = 1;
    for (int k = 0; k < 80; k++) begin
      exp_vec = 2'((k / 10) % 4);
      if ({b, a} !== exp_vec || busy !== 1'b1 || done !== 1'b0) ok = 0;
      step();
    end
    check("t1_sequence", ok, 1);
    check("t1_done", done, 1);
    check("t1_busy_in_done", busy, 0);
    check("t1_ab_in_done", {b, a}, 0);
    check("t1_err", err_cnt, 0);
    check("t1_pass", pass, 1);
    check("t1_dut2_done", done2, 1);
    check("t1_dut2_err_sat", err_cnt2, 3);
    check("t1_dut2_pass", pass2, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_pass_hold", pass, 1);
    check("t1_err_hold", err_cnt, 0);
    step();

    // Stuck-at-0 gate: 01, 10, 11 fail in both passes.
    mode = 1;
    run_pulse(n);
    check("t2_latency", n, 81);
    check("t2_err", err_cnt, 6);
    check("t2_pass", pass, 0);
`ifdef GATE_SWEEP_ERRLOG_EN
    check("t2_first_vld", first_err_vld, 1);
    check("t2_first_vec", first_err_vec, 1);
`endif
    step();
    step();

    // Extra start pulses mid-run must be ignored.
    mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    done_seen = 0;
    while (done !== 1'b1 && n < 300) begin
      start = (n == 20 || n == 50);
      step();
      n++;
    end
    start = 1'b0;
    check("t3_latency", n, 81);
    check("t3_err", err_cnt, 0);
    check("t3_pass", pass, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("t3_no_rerun", done_seen, 0);

    // Reset mid-sweep after some mismatches have accumulated.
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 35; k++) step();
    check("t4_err_before_rst", err_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_ab", {b, a}, 0);
    check("t4_rst_err", err_cnt, 0);
    check("t4_rst_pass", pass, 0);
    check("t4_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("t4_abandoned", done_seen, 0);
    mode = 0;
    run_pulse(n);
    check("t4_clean_latency", n, 81);
    check("t4_clean_err", err_cnt, 0);
    check("t4_clean_pass", pass, 1);
    step();
    step();

    // start held high: back-to-back runs.
    mode = 1;
    start = 1'b1;
    done_seen = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (done === 1'b1) begin
        done_seen++;
        if (k != 81 && k != 163) check("t5_done_time", k, 0);
      end
      if (k == 81)  check("t5_done1", done, 1);
      if (k == 81)  check("t5_err_run1", err_cnt, 6);
      if (k == 82)  check("t5_err_idle_hold", err_cnt, 6);
      if (k == 82)  check("t5_busy_idle", busy, 0);
      if (k == 83)  check("t5_err_cleared", err_cnt, 0);
      if (k == 83)  check("t5_busy_run2", busy, 1);
      if (k == 163) check("t5_done2", done, 1);
      if (k == 163) check("t5_err_run2", err_cnt, 6);
    end
    start = 1'b0;
    check("t5_done_count", done_seen, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_seq.md
# gate_sweep_seq

Self-checking sequencer for the two-input OR gate datapath. On `start` it drives the gate inputs `a`/`b` through every 2-bit input combination. It holds each vector for a programmable number of cycles and samples the gate output on the last hold cycle. Each sample is compared against the expected OR and mismatches are counted. It replaces hand-written delay-based stimulus with a synthesizable, repeatable sweep that sits directly in front of the gate instance.

## Interface
Parameters:
- `HOLD_CYCLES`, default 10: cycles each vector is driven. Must be ≥2.
- `PASSES`, default 2: number of full 4-vector sweeps per run. Must be ≥1.
- `CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: level-sampled run request.
- `a`  out  1: gate input A (to gate `.a`).
- `b`  out  1: gate input B (to gate `.b`).
- `or_o`  in  1: gate output under check.
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: one-cycle pulse at end of run.
- `pass`  out  1: high when the last completed run had zero errors.
- `err_cnt`  out  CNT_W: mismatch count of current/last run; saturating.
- `vec_idx`  out  2: current vector index, where `a`=`vec_idx[0]` and `b`=`vec_idx[1]`.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- **Reset** (async, any state) forces the following; a run in progress is abandoned with no `done`:
  - state=IDLE
  - `a`=`b`=0, `vec_idx`=0
  - `busy`=0, `done`=0, `pass`=0
  - `err_cnt`=0
  - hold timer=0, pass counter=0
- **IDLE:** `a`=`b`=0, `busy`=0.
  - `start`=1 → DRIVE, with `vec_idx`=0, timer=0, pass counter=0, `err_cnt`=0.
  - `pass` and `err_cnt` keep the previous run's result until this transition.
- **DRIVE:** `busy`=1; `a`/`b` follow `vec_idx`.
  - The timer counts 0..HOLD_CYCLES-1.
  - At timer=HOLD_CYCLES-1, `or_o` is compared to `a|b`. A mismatch increments `err_cnt`, saturating at 2^CNT_W-1.
  - The same cycle the timer resets to 0 and the vector advances in order 00→01→10→11, with wrap 11→00 incrementing the pass counter.
  - After vector 11 of pass PASSES-1 is sampled → DONE.
- **DONE:** held for one cycle.
  - `done`=1, `busy`=0, `a`=`b`=0.
  - `pass`=(`err_cnt`==0), using the final count.
  - Then → IDLE.
- `start` while in DRIVE or DONE is ignored. It is not queued.
- A `start` held high continuously triggers back-to-back runs, each separated by the DONE cycle plus one IDLE cycle.

## Timing
- `start` is sampled high on edge T. From T+1, `busy`=1 and `a`/`b` show vector 00.
- Each vector is stable for exactly HOLD_CYCLES cycles. The gate is combinational, so `or_o` has settled well before the sample.
- The compare result lands in `err_cnt` on the edge ending the sample cycle.
- `done` is high in cycle T+1+4·PASSES·HOLD_CYCLES. With defaults, that is 81 cycles after the start edge.
- `err_cnt` is final and `pass` is valid in the `done` cycle, and both hold until the next accepted `start`.
- All outputs are registered; there are no combinational paths from `or_o` or `start` to outputs.

## Configuration
- Macro `GATE_SWEEP_ERRLOG_EN`:
  - **Defined:** adds ports `first_err_vld` (out, 1) and `first_err_vec` (out, 2). On the first mismatch of a run these latch 1 and the failing `vec_idx`; later mismatches do not overwrite them. Both clear on reset and on accepted `start`.
  - **Undefined:** the ports and registers are absent; all other behaviour is identical.

## Structure
- Package `gate_sweep_pkg`:
  - state enum (IDLE/DRIVE/DONE)
  - vector order constants
  - `expected_or(vec)` function, so the bench reuses the same reference
- Sub-module `gate_sweep_timer`: parameterized 0..HOLD_CYCLES-1 counter with `clr`, `en`, and a `last` flag. It is the only sub-module; vector index, pass counter and error counter stay in the top.

## Test plan
- **Correct OR gate, defaults:** `start` pulse → `done` at T+81, `err_cnt`=0, `pass`=1, and `a`/`b` sequence 00,01,10,11 twice with 10 cycles each.
- **`or_o` stuck at 0:** run → `err_cnt`=6, `pass`=0. With ERRLOG: `first_err_vld`=1, `first_err_vec`=01.
- **`or_o` inverted, `CNT_W`=2:** 8 mismatches → `err_cnt` saturates at 3, `pass`=0.
- **`start` pulsed again at T+20 and T+50:** ignored; single `done` at T+81 with counts unchanged.
- **`rst` asserted at T+35 mid-sweep:** the following hold immediately, with no `done`; a new `start` afterwards runs a full clean sweep:
  - `busy`=0, `a`=`b`=0, `err_cnt`=0
  - `pass`=0
- **`start` held high for 200 cycles:** `done` at T+81 and T+163. `err_cnt` clears at the second run's start.
